// File: rtl/spi_regbank_pkg.sv
// spi_regbank_pkg: shared constants and sizing helpers for the SPI register bank.
//   RW_WRITE / RW_READ : encoding of the first frame bit
//   frame_width()      : bits per frame (RW + address + data)
//   cnt_width()        : width of a counter able to hold 0..frame_w
package spi_regbank_pkg;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int frame_width(input int addr_w, input int data_w);
    return 1 + addr_w + data_w;
  endfunction

  function automatic int cnt_width(input int frame_w);
    return $clog2(frame_w + 1);
  endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: STAGES-flop synchroniser for one asynchronous pin, followed by a
// registered edge detector.
//   clk, rst_n : system clock, asynchronous active-low reset
//   d          : asynchronous input pin
//   q          : synchronised level, aligned with rise/fall
//   rise, fall : one-cycle pulses in the first cycle q shows the new level
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_r;
  logic              q_r;
  logic              rise_r;
  logic              fall_r;

  // Synchroniser chain plus edge detection against the previous level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= {STAGES{1'b0}};
      q_r     <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      chain_r <= {chain_r[STAGES-2:0], d};
      q_r     <= chain_r[STAGES-1];
      rise_r  <= chain_r[STAGES-1] & ~q_r;
      fall_r  <= ~chain_r[STAGES-1] & q_r;
    end
  end

  assign q    = q_r;
  assign rise = rise_r;
  assign fall = fall_r;

endmodule

// File: rtl/spi_regbank.sv
// spi_regbank: SPI (mode 0) slave exposing N_CTRL control registers and
// N_STAT read-only status registers. All SPI pins are oversampled in clk_i.
//   clk_i, rstn_i     : system clock, asynchronous active-low reset
//   nss_i/sck_i/sdi_i : SPI chip select (active low), clock, MOSI
//   sdo_o, sdo_oe_o   : MISO and its output enable (enable == busy_o)
//   stat_i            : N_STAT asynchronous status words, packed
//   ctrl_o            : N_CTRL control words, packed
//   wr_stb_o          : one-cycle commit pulse per control register
//   frame_err_o       : one-cycle pulse when a frame is aborted
//   busy_o            : frame in progress
module spi_regbank
  import spi_regbank_pkg::*;
#(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 4,
  parameter int                N_CTRL      = 4,
  parameter int                N_STAT      = 4,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] CTRL_RST    = '0
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     nss_i,
  input  logic                     sck_i,
  input  logic                     sdi_i,
  output logic                     sdo_o,
  output logic                     sdo_oe_o,
  input  logic [N_STAT*DATA_W-1:0] stat_i,
  output logic [N_CTRL*DATA_W-1:0] ctrl_o,
  output logic [N_CTRL-1:0]        wr_stb_o,
  output logic                     frame_err_o,
  output logic                     busy_o
);

  localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
  localparam int CNT_W   = cnt_width(FRAME_W);
  // Counter value seen on the rise that completes the address / the frame.
  localparam logic [CNT_W-1:0] CNT_ADDR = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);

  logic nss_q, nss_rise, nss_fall;
  logic sck_q, sck_rise, sck_fall;
  logic sdi_q, sdi_rise, sdi_fall;

  sync_edge #(.STAGES(SYNC_STAGES)) u_nss (
    .clk(clk_i), .rst_n(rstn_i), .d(nss_i), .q(nss_q), .rise(nss_rise), .fall(nss_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk(clk_i), .rst_n(rstn_i), .d(sck_i), .q(sck_q), .rise(sck_rise), .fall(sck_fall));
  sync_edge #(.STAGES(SYNC_STAGES)) u_sdi (
    .clk(clk_i), .rst_n(rstn_i), .d(sdi_i), .q(sdi_q), .rise(sdi_rise), .fall(sdi_fall));

  logic unused_s;
  assign unused_s = &{1'b0, nss_fall, sck_q, sdi_rise, sdi_fall};

  logic [N_STAT*DATA_W-1:0] stat_sync_r [SYNC_STAGES];
  logic [N_STAT*DATA_W-1:0] stat_q;

  // Plain per-bit synchroniser for the status words.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) stat_sync_r[s] <= '0;
    end else begin
      stat_sync_r[0] <= stat_i;
      for (int s = 1; s < SYNC_STAGES; s++) stat_sync_r[s] <= stat_sync_r[s-1];
    end
  end

  assign stat_q = stat_sync_r[SYNC_STAGES-1];

  logic                     armed_r;
  logic                     busy_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [FRAME_W-2:0]       shift_in_r;
  logic [DATA_W-1:0]        shift_out_r;
  logic                     sdo_r;
  logic [N_CTRL*DATA_W-1:0] ctrl_r;
  logic [N_CTRL-1:0]        wr_stb_r;
  logic                     frame_err_r;

  // Frame contents as they will be once the bit on the current rise is shifted in.
  logic [FRAME_W-1:0]  frame_s;
  logic [ADDR_W-1:0]   addr_s;
  logic [ADDR_W-1:0]   wr_addr_s;
  logic [DATA_W-1:0]   rd_word_s;
  logic [N_CTRL-1:0]   wr_hit_s;

  assign frame_s   = {shift_in_r, sdi_q};
  assign addr_s    = frame_s[ADDR_W-1:0];
  assign wr_addr_s = frame_s[FRAME_W-2 -: ADDR_W];

  // Read-data mux: control word, synchronised status word, or zero if unmapped.
  always_comb begin
    rd_word_s = {DATA_W{1'b0}};
    if (int'(addr_s) < N_CTRL) begin
      rd_word_s = ctrl_r[int'(addr_s)*DATA_W +: DATA_W];
    end else if (int'(addr_s) < N_CTRL + N_STAT) begin
      rd_word_s = stat_q[(int'(addr_s) - N_CTRL)*DATA_W +: DATA_W];
    end else begin
      rd_word_s = {DATA_W{1'b0}};
    end
  end

  // Write decode: only mapped control addresses of a write frame hit.
  always_comb begin
    wr_hit_s = {N_CTRL{1'b0}};
    for (int k = 0; k < N_CTRL; k++) begin
      wr_hit_s[k] = (frame_s[FRAME_W-1] == RW_WRITE) && (wr_addr_s == ADDR_W'(k));
    end
  end

  // Frame engine: bit counter, shift registers, commit and abort detection.
  // armed_r stays low after reset until NSS is seen high, so a frame already
  // running across reset release is ignored and cannot raise an error.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      armed_r     <= 1'b0;
      busy_r      <= 1'b0;
      cnt_r       <= {CNT_W{1'b0}};
      shift_in_r  <= {(FRAME_W-1){1'b0}};
      shift_out_r <= {DATA_W{1'b0}};
      sdo_r       <= 1'b0;
      ctrl_r      <= {N_CTRL{CTRL_RST}};
      wr_stb_r    <= {N_CTRL{1'b0}};
      frame_err_r <= 1'b0;
    end else begin
      wr_stb_r    <= {N_CTRL{1'b0}};
      frame_err_r <= 1'b0;
      busy_r      <= armed_r & ~nss_q;
      if (nss_q) armed_r <= 1'b1;
      // Counter still holds its pre-clear value in the NSS rise cycle.
      if (nss_rise && armed_r && (cnt_r != {CNT_W{1'b0}}) && (cnt_r != CNT_FULL)) begin
        frame_err_r <= 1'b1;
      end
      if (nss_q || !armed_r) begin
        cnt_r       <= {CNT_W{1'b0}};
        shift_in_r  <= {(FRAME_W-1){1'b0}};
        shift_out_r <= {DATA_W{1'b0}};
        sdo_r       <= 1'b0;
      end else if (sck_rise && (cnt_r != CNT_FULL)) begin
        cnt_r      <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        shift_in_r <= frame_s[FRAME_W-2:0];
        if (cnt_r == CNT_ADDR) shift_out_r <= rd_word_s;
        if (cnt_r == CNT_LAST) begin
          for (int k = 0; k < N_CTRL; k++) begin
            if (wr_hit_s[k]) begin
              ctrl_r[k*DATA_W +: DATA_W] <= frame_s[DATA_W-1:0];
              wr_stb_r[k]                <= 1'b1;
            end
          end
        end
      end else if (sck_fall) begin
        // Data phase starts on the first fall after the address is complete.
        if (cnt_r > CNT_ADDR) begin
          sdo_r       <= shift_out_r[DATA_W-1];
          shift_out_r <= {shift_out_r[DATA_W-2:0], 1'b0};
        end else begin
          sdo_r <= 1'b0;
        end
      end
    end
  end

  assign sdo_o       = sdo_r;
  assign sdo_oe_o    = busy_r;
  assign busy_o      = busy_r;
  assign ctrl_o      = ctrl_r;
  assign wr_stb_o    = wr_stb_r;
  assign frame_err_o = frame_err_r;

endmodule

// File: tb/tb_spi_regbank.sv
// Testbench for spi_regbank: table-driven SPI frames plus hand-written
// sequences for status coherence and reset in the middle of a frame.
module tb_spi_regbank;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NC = 4;
  localparam int NS = 4;
  localparam int SS = 2;
  localparam int FW = 1 + AW + DW;

  logic           clk = 1'b0;
  logic           rstn = 1'b0;
  logic           nss = 1'b1;
  logic           sck = 1'b0;
  logic           sdi = 1'b0;
  logic [NS*DW-1:0] stat = '0;
  logic           sdo_o, sdo_oe_o, frame_err_o, busy_o;
  logic [NC*DW-1:0] ctrl_o;
  logic [NC-1:0]    wr_stb_o;

  spi_regbank #(.DATA_W(DW), .ADDR_W(AW), .N_CTRL(NC), .N_STAT(NS),
                .SYNC_STAGES(SS), .CTRL_RST(16'h0000)) dut (
    .clk_i(clk), .rstn_i(rstn), .nss_i(nss), .sck_i(sck), .sdi_i(sdi),
    .sdo_o(sdo_o), .sdo_oe_o(sdo_oe_o), .stat_i(stat), .ctrl_o(ctrl_o),
    .wr_stb_o(wr_stb_o), .frame_err_o(frame_err_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_chk = 0;
  int n_fail = 0;
  int last_rise_cyc = 0;
  int err_cycles = 0;
  int exp_err = 0;
  logic [NC*DW-1:0] model_ctrl = '0;

  typedef struct {
    logic [NC-1:0] stb;
    logic [DW-1:0] word;
    int            addr;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            nbits;
    logic [63:0]   stat;
    logic [DW-1:0] exp_rd;
    logic [NC-1:0] exp_stb;
    logic          exp_err;
  } vec_t;
  vec_t tbl[14];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Commit monitor: every strobe must match the next expected write.
  always @(negedge clk) begin
    sb_t e;
    if (frame_err_o) err_cycles++;
    if (wr_stb_o != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", {60'b0, wr_stb_o}, 64'h0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_bits", {60'b0, wr_stb_o}, {60'b0, e.stb});
        check("strobe_word", {48'b0, ctrl_o[e.addr*DW +: DW]}, {48'b0, e.word});
        check("commit_latency", 64'(cyc - last_rise_cyc), 64'(SS + 2));
      end
    end
  end

  task automatic do_frame(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input int nbits, input int chg_bit, input logic [63:0] chg_val,
                          input int rst_at, output logic [DW-1:0] rd, output logic ap,
                          output logic bsy);
    logic [FW-1:0] fr;
    fr  = {rw, addr, data};
    rd  = '0;
    ap  = 1'b0;
    bsy = 1'b0;
    @(negedge clk);
    nss = 1'b0;
    wait_clk(2);
    for (int i = 0; i < nbits; i++) begin
      sdi = (i < FW) ? fr[FW-1-i] : 1'b1;
      if (i == chg_bit) stat = chg_val;
      if (i == rst_at) begin
        rstn = 1'b0;
        wait_clk(3);
        rstn = 1'b1;
      end
      wait_clk(8);
      if (i == 1) bsy = busy_o & sdo_oe_o;
      if (i >= 1 && i <= AW) ap = ap | sdo_o;
      if (i > AW && i < FW) rd[FW-1-i] = sdo_o;
      sck = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(8);
      sck = 1'b0;
    end
    wait_clk(8);
    nss = 1'b1;
    wait_clk(12);
  endtask

  task automatic post_checks(input string tag);
    check({tag, "_ctrl_words"}, ctrl_o, model_ctrl);
    check({tag, "_err_pulses"}, 64'(err_cycles), 64'(exp_err));
    check({tag, "_sb_drained"}, 64'(sb_q.size()), 64'h0);
    check({tag, "_busy_idle"}, {63'b0, busy_o | sdo_oe_o}, 64'h0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic ap, bsy;
    sb_t e;

    tbl[0]  = '{1'b1, 4'd2,  16'hA5C3, FW,   64'h0, 16'h0000, 4'b0100, 1'b0};
    tbl[1]  = '{1'b0, 4'd2,  16'h0000, FW,   64'h0, 16'hA5C3, 4'b0000, 1'b0};
    tbl[2]  = '{1'b0, 4'd15, 16'h0000, FW,   64'hFFFF_FFFF_FFFF_FFFF, 16'h0000, 4'b0000, 1'b0};
    tbl[3]  = '{1'b1, 4'd1,  16'hFFFF, 10,   64'h0, 16'h0000, 4'b0000, 1'b1};
    tbl[4]  = '{1'b1, 4'd1,  16'h0F0F, FW,   64'h0, 16'h0000, 4'b0010, 1'b0};
    tbl[5]  = '{1'b1, 4'd0,  16'hBEEF, FW+3, 64'h0, 16'h0000, 4'b0001, 1'b0};
    tbl[6]  = '{1'b1, 4'd6,  16'h5555, FW,   64'h0, 16'h0000, 4'b0000, 1'b0};
    tbl[7]  = '{1'b1, 4'd9,  16'h3333, FW,   64'h0, 16'h0000, 4'b0000, 1'b0};
    tbl[8]  = '{1'b0, 4'd0,  16'h0000, FW,   64'h0, 16'hBEEF, 4'b0000, 1'b0};
    tbl[9]  = '{1'b0, 4'd1,  16'h0000, FW,   64'h0, 16'h0F0F, 4'b0000, 1'b0};
    tbl[10] = '{1'b0, 4'd4,  16'h0000, FW,   64'h0123_4567_89AB_CDEF, 16'hCDEF, 4'b0000, 1'b0};
    tbl[11] = '{1'b0, 4'd7,  16'h0000, FW,   64'h0123_4567_89AB_CDEF, 16'h0123, 4'b0000, 1'b0};
    tbl[12] = '{1'b0, 4'd6,  16'h0000, FW,   64'h0123_4567_89AB_CDEF, 16'h4567, 4'b0000, 1'b0};
    tbl[13] = '{1'b0, 4'd3,  16'h0000, FW,   64'h0, 16'h0000, 4'b0000, 1'b0};

    // Reset state
    wait_clk(5);
    check("rst_ctrl", ctrl_o, 64'h0);
    check("rst_stb", {60'b0, wr_stb_o}, 64'h0);
    check("rst_oe", {63'b0, sdo_oe_o}, 64'h0);
    check("rst_busy", {63'b0, busy_o}, 64'h0);
    check("rst_sdo", {63'b0, sdo_o}, 64'h0);
    check("rst_err", {63'b0, frame_err_o}, 64'h0);
    rstn = 1'b1;
    wait_clk(10);

    for (int v = 0; v < 14; v++) begin
      stat = tbl[v].stat;
      if (tbl[v].exp_stb != '0) begin
        e.stb  = tbl[v].exp_stb;
        e.word = tbl[v].data;
        e.addr = int'(tbl[v].addr);
        sb_q.push_back(e);
        model_ctrl[int'(tbl[v].addr)*DW +: DW] = tbl[v].data;
      end
      if (tbl[v].exp_err) exp_err++;
      do_frame(tbl[v].rw, tbl[v].addr, tbl[v].data, tbl[v].nbits, -1, 64'h0, -1, rd, ap, bsy);
      if (tbl[v].rw == 1'b0) check($sformatf("vec%0d_read", v), {48'b0, rd}, {48'b0, tbl[v].exp_rd});
      check($sformatf("vec%0d_addr_phase_sdo", v), {63'b0, ap}, 64'h0);
      check($sformatf("vec%0d_busy", v), {63'b0, bsy}, 64'h1);
      post_checks($sformatf("vec%0d", v));
    end

    // Status word captured at address completion, held through the data phase
    stat = 64'h0000_0000_1234_0000;
    do_frame(1'b0, 4'd5, 16'h0000, FW, 10, 64'h0000_0000_FFFF_0000, -1, rd, ap, bsy);
    check("stat_coherent", {48'b0, rd}, 64'h1234);
    do_frame(1'b0, 4'd5, 16'h0000, FW, -1, 64'h0, -1, rd, ap, bsy);
    check("stat_refresh", {48'b0, rd}, 64'hFFFF);
    post_checks("stat");

    // Reset in the middle of a write, released while NSS still low
    model_ctrl = '0;
    do_frame(1'b1, 4'd3, 16'h7777, FW, -1, 64'h0, 12, rd, ap, bsy);
    post_checks("midrst");
    e.stb  = 4'b1000;
    e.word = 16'h7777;
    e.addr = 3;
    sb_q.push_back(e);
    model_ctrl[3*DW +: DW] = 16'h7777;
    do_frame(1'b1, 4'd3, 16'h7777, FW, -1, 64'h0, -1, rd, ap, bsy);
    post_checks("after_rst");
    do_frame(1'b0, 4'd3, 16'h0000, FW, -1, 64'h0, -1, rd, ap, bsy);
    check("after_rst_read", {48'b0, rd}, 64'h7777);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
